uart_fifo_reader: RTL
=====================

Name: uart_fifo_reader

Overview:
Parametrised successor to the monitor's UART read interface. It drains words from the capture FIFO RAM through a rdreq/rdack read port and serialises each word into BW-bit beats for the UART transmitter, most-significant beat first. It adds wrap-around addressing at an arbitrary DEPTH, tag-based word discard, an enable gate, and status counters. It sits in the mon/uart path between the capture FIFO and the UART TX core.

Parameters:
DW, 18, FIFO word width in bits (>= 2).
AW, 11, FIFO read address width.
DEPTH, 2048, number of FIFO entries (2..2^AW; need not be a power of two).
BW, 8, UART beat width in bits.
TAG_EN, 1, 1 enables discard of tagged words; 0 sends every word.
TAG_W, 4, tag field width, taken from word bits [DW-1:DW-TAG_W].
SKIP_TAG, 4'hF, tag value whose words are discarded.

Ports:
clk  in  1  clock
rst  in  1  reset
en  in  1  drain enable
empty  in  1  FIFO empty flag
rdreq  out  1  FIFO read request
rdack  in  1  FIFO read acknowledge; rdata is valid in the same cycle
raddr  out  AW  FIFO read address
rdata  in  DW  FIFO read data
uart_req  out  1  UART beat request
uart_ack  in  1  UART beat acknowledge
uart_dat  out  BW  UART beat data
uart_last  out  1  current beat is the last beat of the word
word_cnt  out  16  count of words fully sent
skip_cnt  out  16  count of words discarded by tag
busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous and active-high (rst), single clock clk; reset is sampled on the rising edge of clk.
- Reset values: state IDLE; rdreq, uart_req, uart_last, busy = 0; raddr, word_cnt, skip_cnt = 0; uart_dat = 0; captured word register = 0; beat index = 0.
- NBEAT = ceil(DW/BW). The captured word is zero-extended to NBEAT*BW bits. Beat k (k = 0..NBEAT-1) is bits [(NBEAT-k)*BW-1 : (NBEAT-k-1)*BW]. With DW=18 and BW=8: beat0 = {6'b0, d[17:16]}, beat1 = d[15:8], beat2 = d[7:0].
- States:
  - IDLE: go to READ when en=1 and empty=0; otherwise stay in IDLE.
  - READ: rdreq=1. On rdack, capture rdata.
    - If TAG_EN=1 and the tag field equals SKIP_TAG: increment raddr, increment skip_cnt, go to IDLE.
    - Otherwise: set beat index to 0 and go to SEND.
    - Without rdack: stay in READ, with rdreq held at 1.
  - SEND: uart_req=1; uart_dat = current beat; uart_last = (beat index == NBEAT-1).
    - On uart_ack with a non-last beat: increment the beat index and stay in SEND.
    - On uart_ack with the last beat: increment raddr, increment word_cnt, go to IDLE.
- rdreq and uart_req are decoded from the registered state only, with no combinational path from rdack or uart_ack.
- uart_dat and uart_last are held stable while uart_req=1 and uart_ack=0.
- IDLE always lasts at least one cycle after a word completes or is discarded, so the FIFO can update empty from the new raddr.
- Raddr wrap: when raddr = DEPTH-1, the next increment gives 0.
- Counter wrap: word_cnt and skip_cnt wrap from 16'hFFFF to 0.
- en is sampled in IDLE only. Deasserting en mid-word does not abort the word; the current word completes (or is discarded) normally.
- rdack outside READ and uart_ack outside SEND are ignored.
- Empty: when empty=1 in IDLE, no rdreq is issued. Empty is not re-checked in READ or SEND.
- Reset asserted mid-operation: all state returns to the reset values on the next edge. A partially sent word is dropped and raddr is not advanced by it.
- Latency: with zero-wait handshakes, one word takes 1 (IDLE) + 1 (READ) + NBEAT (SEND) cycles, i.e. 5 cycles for the default parameters.

Test Plan:
- Default parameters; en=1, empty=0, FIFO[0]=18'h2A5C3, immediate rdack and uart_ack -> beats 8'h02, 8'hA5, 8'hC3 on consecutive cycles; uart_last=1 on the third beat only; afterwards raddr=1, word_cnt=1.
- Word 18'h3C001 (tag 4'hF) at addr 0, then 18'h00042 at addr 1 -> no UART beats for addr 0; skip_cnt=1; addr 1 sends 8'h00, 8'h00, 8'h42; word_cnt=1, raddr=2.
- uart_ack stalled 5 cycles on beat1 -> uart_req stays 1 and uart_dat is held at beat1 throughout; the sequence resumes unchanged when uart_ack is given.
- DEPTH=5, AW=3, 6 words drained -> raddr sequence 0,1,2,3,4,0.
- en dropped during beat0 -> all 3 beats still sent; state returns to IDLE and no new rdreq is issued while en=0, even with empty=0.
- rst pulsed high during beat1 -> next cycle: state IDLE, uart_req=0, raddr unchanged from its pre-word value, word_cnt unchanged.

Source files
------------

// File: rtl/uart_fifo_reader.sv
// Drains capture-FIFO words over a rdreq/rdack port and serialises each word
// into BW-bit UART beats, most-significant beat first, with tag-based discard.
module uart_fifo_reader #(
  parameter int DW = 18,
  parameter int AW = 11,
  parameter int DEPTH = 2048,
  parameter int BW = 8,
  parameter int TAG_EN = 1,
  parameter int TAG_W = 4,
  parameter logic [TAG_W-1:0] SKIP_TAG = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          empty,
  output logic          rdreq,
  input  logic          rdack,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic          uart_req,
  input  logic          uart_ack,
  output logic [BW-1:0] uart_dat,
  output logic          uart_last,
  output logic [15:0]   word_cnt,
  output logic [15:0]   skip_cnt,
  output logic          busy
);

  localparam int NBEAT = (DW + BW - 1) / BW;
  localparam int NBW = NBEAT * BW;
  localparam int IW = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBEAT - 1);
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   cap_word;
  logic [IW-1:0]   beat_idx;

  // Beat k of the zero-extended word; beat 0 carries the most-significant bits.
  function automatic logic [BW-1:0] beat_of(input logic [DW-1:0] w, input logic [IW-1:0] k);
    logic [NBW-1:0] ext;
    logic [NBW-1:0] sh;
    ext = NBW'(w);
    sh = ext >> ((NBEAT - 1 - int'(k)) * BW);
    return sh[BW-1:0];
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == ADDR_MAX) ? {AW{1'b0}} : a + AW'(1);
  endfunction

  function automatic logic is_skip(input logic [DW-1:0] w);
    return (TAG_EN != 0) && (w[DW-1 -: TAG_W] == SKIP_TAG);
  endfunction

  // Read/serialise FSM; every output is registered alongside the state so that
  // rdreq and uart_req never depend combinationally on the acknowledges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdreq     <= 1'b0;
      uart_req  <= 1'b0;
      uart_last <= 1'b0;
      busy      <= 1'b0;
      raddr     <= {AW{1'b0}};
      word_cnt  <= 16'd0;
      skip_cnt  <= 16'd0;
      uart_dat  <= {BW{1'b0}};
      cap_word  <= {DW{1'b0}};
      beat_idx  <= {IW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (en && !empty) begin
            state <= READ;
            rdreq <= 1'b1;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (rdack) begin
            cap_word <= rdata;
            rdreq    <= 1'b0;
            if (is_skip(rdata)) begin
              raddr    <= next_addr(raddr);
              skip_cnt <= skip_cnt + 16'd1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              beat_idx  <= {IW{1'b0}};
              uart_dat  <= beat_of(rdata, {IW{1'b0}});
              uart_last <= (NBEAT == 1);
              uart_req  <= 1'b1;
              state     <= SEND;
            end
          end
        end
        SEND: begin
          if (uart_ack) begin
            if (beat_idx == LAST_IDX) begin
              raddr     <= next_addr(raddr);
              word_cnt  <= word_cnt + 16'd1;
              uart_req  <= 1'b0;
              uart_last <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              beat_idx  <= beat_idx + IW'(1);
              uart_dat  <= beat_of(cap_word, beat_idx + IW'(1));
              uart_last <= ((beat_idx + IW'(1)) == LAST_IDX);
            end
          end
        end
        default: begin
          state     <= IDLE;
          rdreq     <= 1'b0;
          uart_req  <= 1'b0;
          uart_last <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
